// File: rtl/edge_scan_ctrl.sv
// Purpose : raster-scan controller for the 3x3 edge window stage; tracks the
//           (col,row) of the next pixel and flags windows, line ends and frame end.
// Latency : start -> pix_ready in 1 cycle; accept -> win_valid/line_end/frame_done in 1 cycle.
// Backpr. : pix_ready is high for the whole SCAN state; upstream stalls by dropping pix_valid.
//
// Ports:
//   clk, n_rst           clock, async active-low reset
//   clear                synchronous abort back to IDLE (highest priority)
//   start                begin a frame; img_width/img_height sampled with it
//   pix_valid/pix_ready  pixel handshake
//   busy                 frame scan in progress
//   cfg_err              one-cycle pulse: start rejected (dimension < 3)
//   win_valid, win_col, win_row   window-centre coordinates (held when not valid)
//   line_end, frame_done one-cycle pulses for last pixel of a row / of the frame
module edge_scan_ctrl #(
  parameter int COORD_BITS = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [COORD_BITS-1:0] img_width,
  input  logic [COORD_BITS-1:0] img_height,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  win_valid,
  output logic [COORD_BITS-1:0] win_col,
  output logic [COORD_BITS-1:0] win_row,
  output logic                  line_end,
  output logic                  frame_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [COORD_BITS-1:0] r_col;
  logic [COORD_BITS-1:0] r_row;
  logic [COORD_BITS-1:0] r_w;
  logic [COORD_BITS-1:0] r_h;

  logic                  r_cfg_err;
  logic                  r_win_valid;
  logic [COORD_BITS-1:0] r_win_col;
  logic [COORD_BITS-1:0] r_win_row;
  logic                  r_line_end;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_dims_ok;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_window;
  logic                  w_pix_ready;
  logic                  w_busy;

  // Dimensions below 3 cannot hold a 3x3 window and would also make W-1/H-1
  // comparisons meaningless, so they are rejected at start.
  assign w_dims_ok   = (img_width >= COORD_BITS'(3)) && (img_height >= COORD_BITS'(3));
  assign w_start_ok  = (r_state == ST_IDLE) && start && w_dims_ok;
  assign w_start_bad = (r_state == ST_IDLE) && start && !w_dims_ok;
  assign w_accept    = pix_valid && w_pix_ready;
  assign w_col_last  = (r_col == r_w - COORD_BITS'(1));
  assign w_row_last  = (r_row == r_h - COORD_BITS'(1));
  // A pixel at (c,r) closes the window centred on (c-1,r-1).
  assign w_window    = (r_col >= COORD_BITS'(2)) && (r_row >= COORD_BITS'(2));

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_pix_ready  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_dims_ok) begin
          w_next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_pix_ready = 1'b1;
        w_busy      = 1'b1;
        if (w_accept && w_col_last && w_row_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (clear) begin
      w_next_state = ST_IDLE;
    end
  end

  // Position counters and latched frame size
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col <= '0;
      r_row <= '0;
      r_w   <= '0;
      r_h   <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start_ok) begin
      r_w   <= img_width;
      r_h   <= img_height;
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        // Final pixel of the frame rewinds both counters for the next start.
        r_row <= w_row_last ? '0 : r_row + COORD_BITS'(1);
      end else begin
        r_col <= r_col + COORD_BITS'(1);
      end
    end
  end

  // Registered pulses; window coordinates only move with a valid window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cfg_err    <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_col    <= '0;
      r_win_row    <= '0;
      r_line_end   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cfg_err    <= !clear && w_start_bad;
      r_win_valid  <= !clear && w_accept && w_window;
      r_line_end   <= !clear && w_accept && w_col_last;
      r_frame_done <= !clear && w_accept && w_col_last && w_row_last;
      if (!clear && w_accept && w_window) begin
        r_win_col <= r_col - COORD_BITS'(1);
        r_win_row <= r_row - COORD_BITS'(1);
      end
    end
  end

  assign pix_ready  = w_pix_ready;
  assign busy       = w_busy;
  assign cfg_err    = r_cfg_err;
  assign win_valid  = r_win_valid;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign line_end   = r_line_end;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Purpose : self-checking bench for edge_scan_ctrl (10-bit main instance plus a
//           4-bit instance for counter-width wrap at the boundary).
// Checks  : vector table, directed frame sequences, random traffic vs a
//           pixel-index reference model (col = n % W, row = n / W).
module tb_edge_scan_ctrl;
  localparam int CB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          clear, start, pix_valid;
  logic [CB-1:0] img_width, img_height;
  logic          pix_ready, busy, cfg_err, win_valid, line_end, frame_done;
  logic [CB-1:0] win_col, win_row;

  logic          clear4, start4, valid4;
  logic [3:0]    w4, h4;
  logic          ready4, busy4, cfg4, wv4, le4, fd4;
  logic [3:0]    wc4, wr4;

  edge_scan_ctrl #(.COORD_BITS(CB)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(start),
    .img_width(img_width), .img_height(img_height), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .cfg_err(cfg_err), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .line_end(line_end), .frame_done(frame_done)
  );

  edge_scan_ctrl #(.COORD_BITS(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .clear(clear4), .start(start4),
    .img_width(w4), .img_height(h4), .pix_valid(valid4),
    .pix_ready(ready4), .busy(busy4), .cfg_err(cfg4), .win_valid(wv4),
    .win_col(wc4), .win_row(wr4), .line_end(le4), .frame_done(fd4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_scan;
  int m_w, m_h, m_n;
  bit e_cfg, e_wv, e_le, e_fd;
  int e_col, e_row;

  function automatic void model_reset();
    m_scan = 0; m_n = 0; m_w = 0; m_h = 0;
    e_cfg = 0; e_wv = 0; e_le = 0; e_fd = 0; e_col = 0; e_row = 0;
  endfunction

  function automatic void model_step(bit c, bit s, int w, int h, bit v);
    int cc, rr;
    e_cfg = 0; e_wv = 0; e_le = 0; e_fd = 0;
    if (c) begin
      m_scan = 0; m_n = 0;
    end else if (!m_scan) begin
      if (s) begin
        if (w >= 3 && h >= 3) begin
          m_scan = 1; m_w = w; m_h = h; m_n = 0;
        end else begin
          e_cfg = 1;
        end
      end
    end else if (v) begin
      cc = m_n % m_w;
      rr = m_n / m_w;
      e_le = (cc == m_w - 1);
      e_fd = (m_n == m_w * m_h - 1);
      if (cc >= 2 && rr >= 2) begin
        e_wv = 1; e_col = cc - 1; e_row = rr - 1;
      end
      m_n++;
      if (e_fd) begin
        m_scan = 0; m_n = 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".pix_ready"},  pix_ready,  m_scan);
    check({tag, ".busy"},       busy,       m_scan);
    check({tag, ".cfg_err"},    cfg_err,    e_cfg);
    check({tag, ".win_valid"},  win_valid,  e_wv);
    check({tag, ".win_col"},    win_col,    e_col);
    check({tag, ".win_row"},    win_row,    e_row);
    check({tag, ".line_end"},   line_end,   e_le);
    check({tag, ".frame_done"}, frame_done, e_fd);
  endtask

  // Event logs filled by step()
  int win_c[$], win_r[$], le_at[$];
  int acc_cnt, fd_cnt, repeat_cnt;
  bit prev_wv, prev_le, prev_fd;

  task automatic clear_logs();
    win_c.delete(); win_r.delete(); le_at.delete();
    acc_cnt = 0; fd_cnt = 0; repeat_cnt = 0;
    prev_wv = 0; prev_le = 0; prev_fd = 0;
  endtask

  task automatic step(input string tag, input bit c, input bit s, input int w, input int h, input bit v);
    bit will_acc;
    will_acc = m_scan && v && !c;
    clear = c; start = s; img_width = CB'(w); img_height = CB'(h); pix_valid = v;
    model_step(c, s, w, h, v);
    @(posedge clk);
    #1;
    if (will_acc) acc_cnt++;
    compare_all(tag);
    if (win_valid) begin win_c.push_back(int'(win_col)); win_r.push_back(int'(win_row)); end
    if (line_end) le_at.push_back(acc_cnt);
    if (frame_done) fd_cnt++;
    if ((win_valid && prev_wv) || (line_end && prev_le) || (frame_done && prev_fd)) repeat_cnt++;
    prev_wv = win_valid; prev_le = line_end; prev_fd = frame_done;
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input bit toggle);
    bit got;
    got = 0;
    clear_logs();
    step({tag, ".start"}, 0, 1, w, h, 0);
    for (int i = 0; i < 4 * w * h + 8; i++) begin
      step(tag, 0, 0, w, h, toggle ? (i % 2 == 0) : 1'b1);
      if (frame_done) begin got = 1; break; end
    end
    check({tag, ".frame_done_seen"}, got, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit c, s; int w, h; bit v;
    bit rdy, cfg, wv; int col, row; bit le, fd;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(bit c, bit s, int w, int h, bit v,
                              bit rdy, bit cfg, bit wv, int col, int row, bit le, bit fd);
    vec_t t;
    t.c = c; t.s = s; t.w = w; t.h = h; t.v = v;
    t.rdy = rdy; t.cfg = cfg; t.wv = wv; t.col = col; t.row = row; t.le = le; t.fd = fd;
    return t;
  endfunction

  initial begin
    // Illegal start, idle cycle, then a full 3x3 frame with pix_valid held high.
    tbl[0]  = mk(0, 1, 2, 10, 0,  0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 2, 10, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 3, 3,  0,  1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 3, 3,  1,  1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 3, 3,  1,  0, 0, 1, 1, 1, 1, 1);
    tbl[12] = mk(0, 0, 3, 3,  1,  0, 0, 0, 1, 1, 0, 0);

    n_rst = 0; clear = 0; start = 0; pix_valid = 0; img_width = '0; img_height = '0;
    clear4 = 0; start4 = 0; valid4 = 0; w4 = '0; h4 = '0;
    model_reset();
    #12;
    check("rst.pix_ready", pix_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.cfg_err", cfg_err, 0);
    check("rst.win_valid", win_valid, 0);
    check("rst.win_col", win_col, 0);
    check("rst.win_row", win_row, 0);
    check("rst.line_end", line_end, 0);
    check("rst.frame_done", frame_done, 0);
    n_rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      clear = tbl[i].c; start = tbl[i].s; pix_valid = tbl[i].v;
      img_width = CB'(tbl[i].w); img_height = CB'(tbl[i].h);
      model_step(tbl[i].c, tbl[i].s, tbl[i].w, tbl[i].h, tbl[i].v);
      @(posedge clk); #1;
      check($sformatf("tbl%0d.pix_ready", i), pix_ready, tbl[i].rdy);
      check($sformatf("tbl%0d.busy", i), busy, tbl[i].rdy);
      check($sformatf("tbl%0d.cfg_err", i), cfg_err, tbl[i].cfg);
      check($sformatf("tbl%0d.win_valid", i), win_valid, tbl[i].wv);
      check($sformatf("tbl%0d.win_col", i), win_col, tbl[i].col);
      check($sformatf("tbl%0d.win_row", i), win_row, tbl[i].row);
      check($sformatf("tbl%0d.line_end", i), line_end, tbl[i].le);
      check($sformatf("tbl%0d.frame_done", i), frame_done, tbl[i].fd);
    end

    // W=4, H=3 streaming
    run_frame("f4x3", 4, 3, 0);
    check("f4x3.accepts", acc_cnt, 12);
    check("f4x3.nwin", win_c.size(), 2);
    if (win_c.size() == 2) begin
      check("f4x3.win0_col", win_c[0], 1); check("f4x3.win0_row", win_r[0], 1);
      check("f4x3.win1_col", win_c[1], 2); check("f4x3.win1_row", win_r[1], 1);
    end
    check("f4x3.nle", le_at.size(), 3);
    if (le_at.size() == 3) begin
      check("f4x3.le0", le_at[0], 4); check("f4x3.le1", le_at[1], 8); check("f4x3.le2", le_at[2], 12);
    end
    check("f4x3.busy_at_done", busy, 0);
    check("f4x3.fd_count", fd_cnt, 1);

    // Back-to-back: start sampled in the frame_done cycle
    step("b2b.start", 0, 1, 3, 3, 0);
    check("b2b.ready", pix_ready, 1);
    step("b2b.clr", 1, 0, 3, 3, 0);

    // W=5, H=4 with pix_valid toggling
    run_frame("f5x4", 5, 4, 1);
    check("f5x4.accepts", acc_cnt, 20);
    check("f5x4.nwin", win_c.size(), 6);
    if (win_c.size() == 6) begin
      check("f5x4.last_col", win_c[5], 3); check("f5x4.last_row", win_r[5], 2);
    end
    check("f5x4.single_cycle", repeat_cnt, 0);

    // clear mid-row at (2,1) together with start
    clear_logs();
    step("clr.start", 0, 1, 4, 3, 0);
    for (int i = 0; i < 6; i++) step("clr.acc", 0, 0, 4, 3, 1);
    step("clr.abort", 1, 1, 4, 3, 1);
    check("clr.ready", pix_ready, 0);
    check("clr.no_fd", frame_done, 0);
    step("clr.idle", 0, 0, 4, 3, 1);
    run_frame("clr.rescan", 4, 3, 0);
    check("clr.rescan_acc", acc_cnt, 12);
    if (win_c.size() > 0) check("clr.first_win_col", win_c[0], 1);
    else check("clr.first_win_seen", 0, 1);

    // Async reset mid-frame
    step("ar.start", 0, 1, 5, 4, 0);
    for (int i = 0; i < 13; i++) step("ar.acc", 0, 0, 5, 4, 1);
    #2 n_rst = 0;
    #1;
    check("ar.pix_ready", pix_ready, 0);
    check("ar.busy", busy, 0);
    check("ar.win_valid", win_valid, 0);
    check("ar.win_col", win_col, 0);
    check("ar.win_row", win_row, 0);
    check("ar.line_end", line_end, 0);
    check("ar.frame_done", frame_done, 0);
    model_reset();
    pix_valid = 0;
    #4 n_rst = 1;
    @(posedge clk); #1;
    run_frame("ar.f3x3", 3, 3, 0);
    check("ar.nwin", win_c.size(), 1);
    if (win_c.size() == 1) begin
      check("ar.win_col1", win_c[0], 1); check("ar.win_row1", win_r[0], 1);
    end

    // Randomized traffic vs model
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
           $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 1));
    end
    step("rnd.clr", 1, 0, 3, 3, 0);

    // COORD_BITS=4, W=15, H=3: column counter reaches the top of its range
    begin
      int nwin, nle, nfd, lastc, lastr, maxc;
      bit done4;
      nwin = 0; nle = 0; nfd = 0; lastc = -1; lastr = -1; maxc = 0; done4 = 0;
      w4 = 4'd15; h4 = 4'd3; start4 = 1;
      @(posedge clk); #1;
      start4 = 0; valid4 = 1;
      check("w4.ready", ready4, 1);
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (wv4) begin
          nwin++; lastc = int'(wc4); lastr = int'(wr4);
          if (int'(wc4) > maxc) maxc = int'(wc4);
        end
        if (le4) nle++;
        if (fd4) begin nfd++; done4 = 1; break; end
      end
      valid4 = 0;
      check("w4.done_seen", done4, 1);
      check("w4.nwin", nwin, 13);
      check("w4.max_col", maxc, 13);
      check("w4.last_col", lastc, 13);
      check("w4.last_row", lastr, 1);
      check("w4.nle", nle, 3);
      check("w4.busy_at_done", busy4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
